// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared widths, screen defaults and scheduler state encoding
package gfx_pkg;

  localparam int COORD_W   = 10;
  localparam int COLOR_W   = 12;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_RUN        = 3'd3,
    ST_SERIAL     = 3'd4
  } sched_state_t;

endpackage

// File: rtl/quad_point_serializer.sv
// rtl/quad_point_serializer.sv - latches a 4-point burst and emits clipped, de-duplicated pixels
// Ports: start latches in_* and begins a 4-slot walk; pix_* is the pixel
// handshake; done pulses in the cycle the last slot (idx 3) retires.
module quad_point_serializer
  import gfx_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  input  logic [COORD_W-1:0] in_x_0,
  input  logic [COORD_W-1:0] in_x_1,
  input  logic [COORD_W-1:0] in_x_2,
  input  logic [COORD_W-1:0] in_x_3,
  input  logic [COORD_W-1:0] in_y_0,
  input  logic [COORD_W-1:0] in_y_1,
  input  logic [COORD_W-1:0] in_y_2,
  input  logic [COORD_W-1:0] in_y_3,
  input  logic [COLOR_W-1:0] in_color,
  output logic               pix_rts,
  input  logic               pix_rtr,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               done
);

  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_RES);

  logic [COORD_W-1:0] pt_x [4];
  logic [COORD_W-1:0] pt_y [4];
  logic [COLOR_W-1:0] color_q;
  logic [1:0]         idx;
  logic               active;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               pt_ok, dup, step;

  // A slot is emitted only if on-screen and not equal to any earlier slot
  // (earlier off-screen slots still count, which is harmless since an equal
  // point would be off-screen too).
  always_comb begin
    cur_x = pt_x[idx];
    cur_y = pt_y[idx];
    dup   = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if ((2'(j) < idx) && (pt_x[j] == cur_x) && (pt_y[j] == cur_y)) dup = 1'b1;
    end
    pt_ok   = (cur_x < H_LIM) && (cur_y < V_LIM) && !dup;
    pix_rts = active && pt_ok;
    step    = active && (!pt_ok || pix_rtr);
    done    = step && (idx == 2'd3);
  end

  // Outputs come straight from the held latch so they cannot move under a stall.
  assign pix_x     = cur_x;
  assign pix_y     = cur_y;
  assign pix_color = color_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 4; i++) begin
        pt_x[i] <= '0;
        pt_y[i] <= '0;
      end
      color_q <= '0;
      idx     <= 2'd0;
      active  <= 1'b0;
    end else if (start) begin
      pt_x[0] <= in_x_0;
      pt_x[1] <= in_x_1;
      pt_x[2] <= in_x_2;
      pt_x[3] <= in_x_3;
      pt_y[0] <= in_y_0;
      pt_y[1] <= in_y_1;
      pt_y[2] <= in_y_2;
      pt_y[3] <= in_y_3;
      color_q <= in_color;
      idx     <= 2'd0;
      active  <= 1'b1;
    end else if (step) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) active <= 1'b0;
    end
  end

endmodule

// File: rtl/ellipse_sched.sv
// rtl/ellipse_sched.sv - round-robin ellipse drawer scheduler with burst-to-pixel serializer
// Ports: req0_*/req1_* command requesters; drw_* command to the drawer;
// pt_* 4-point bursts from the drawer; pix_* pixel write stream;
// busy high outside IDLE; grant_id is the requester being served.
module ellipse_sched
  import gfx_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               req0_rts,
  output logic               req0_rtr,
  input  logic [COORD_W-1:0] req0_x0,
  input  logic [COORD_W-1:0] req0_y0,
  input  logic [COORD_W-1:0] req0_a,
  input  logic [COORD_W-1:0] req0_b,
  input  logic [COLOR_W-1:0] req0_color,
  input  logic               req1_rts,
  output logic               req1_rtr,
  input  logic [COORD_W-1:0] req1_x0,
  input  logic [COORD_W-1:0] req1_y0,
  input  logic [COORD_W-1:0] req1_a,
  input  logic [COORD_W-1:0] req1_b,
  input  logic [COLOR_W-1:0] req1_color,
  output logic               drw_rts,
  input  logic               drw_rtr,
  output logic [COORD_W-1:0] drw_x0,
  output logic [COORD_W-1:0] drw_y0,
  output logic [COORD_W-1:0] drw_a,
  output logic [COORD_W-1:0] drw_b,
  output logic [COLOR_W-1:0] drw_color,
  input  logic               pt_rts,
  output logic               pt_rtr,
  input  logic [COORD_W-1:0] pt_x_0,
  input  logic [COORD_W-1:0] pt_x_1,
  input  logic [COORD_W-1:0] pt_x_2,
  input  logic [COORD_W-1:0] pt_x_3,
  input  logic [COORD_W-1:0] pt_y_0,
  input  logic [COORD_W-1:0] pt_y_1,
  input  logic [COORD_W-1:0] pt_y_2,
  input  logic [COORD_W-1:0] pt_y_3,
  input  logic [COLOR_W-1:0] pt_color,
  output logic               pix_rts,
  input  logic               pix_rtr,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               grant_id
);

  sched_state_t state, state_nxt;
  logic last_grant, sel, any_req;
  logic req_xfer, run_finish, ser_start, ser_done;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_rtr   = 1'b0;
    req1_rtr   = 1'b0;
    drw_rts    = 1'b0;
    pt_rtr     = 1'b0;
    ser_start  = 1'b0;
    req_xfer   = 1'b0;
    run_finish = 1'b0;
    any_req    = req0_rts | req1_rts;
    // On a tie the requester not served last wins; otherwise whoever asks.
    sel        = (req0_rts && req1_rts) ? ~last_grant : req1_rts;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          req0_rtr  = ~sel;
          req1_rtr  = sel;
          req_xfer  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        drw_rts = 1'b1;
        if (drw_rtr) state_nxt = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // drw_rtr still reads "idle" right after the handoff; wait for it to drop.
        if (!drw_rtr) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pt_rtr = 1'b1;
        if (pt_rts) begin
          ser_start = 1'b1;
          state_nxt = ST_SERIAL;
        end else if (drw_rtr) begin
          run_finish = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_SERIAL: begin
        if (ser_done) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      drw_x0     <= '0;
      drw_y0     <= '0;
      drw_a      <= '0;
      drw_b      <= '0;
      drw_color  <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (req_xfer) begin
        drw_x0    <= sel ? req1_x0    : req0_x0;
        drw_y0    <= sel ? req1_y0    : req0_y0;
        drw_a     <= sel ? req1_a     : req0_a;
        drw_b     <= sel ? req1_b     : req0_b;
        drw_color <= sel ? req1_color : req0_color;
        grant_id  <= sel;
      end
      if (run_finish) last_grant <= grant_id;
    end
  end

  assign busy = (state != ST_IDLE);

  quad_point_serializer #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_ser (
    .clk      (clk),
    .rst_     (rst_),
    .start    (ser_start),
    .in_x_0   (pt_x_0),
    .in_x_1   (pt_x_1),
    .in_x_2   (pt_x_2),
    .in_x_3   (pt_x_3),
    .in_y_0   (pt_y_0),
    .in_y_1   (pt_y_1),
    .in_y_2   (pt_y_2),
    .in_y_3   (pt_y_3),
    .in_color (pt_color),
    .pix_rts  (pix_rts),
    .pix_rtr  (pix_rtr),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_color(pix_color),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_ellipse_sched.sv
// tb/tb_ellipse_sched.sv - directed self-checking bench for ellipse_sched
module tb_ellipse_sched;

  logic clk = 1'b0;
  logic rst_;
  logic req0_rts, req0_rtr, req1_rts, req1_rtr;
  logic [9:0] req0_x0, req0_y0, req0_a, req0_b, req1_x0, req1_y0, req1_a, req1_b;
  logic [11:0] req0_color, req1_color;
  logic drw_rts, drw_rtr;
  logic [9:0] drw_x0, drw_y0, drw_a, drw_b;
  logic [11:0] drw_color;
  logic pt_rts, pt_rtr;
  logic [9:0] pt_x_0, pt_x_1, pt_x_2, pt_x_3, pt_y_0, pt_y_1, pt_y_2, pt_y_3;
  logic [11:0] pt_color;
  logic pix_rts, pix_rtr;
  logic [9:0] pix_x, pix_y;
  logic [11:0] pix_color;
  logic busy, grant_id;

  int checks = 0;
  int failures = 0;
  logic [31:0] pix_q[$];

  ellipse_sched dut (
    .clk(clk), .rst_(rst_),
    .req0_rts(req0_rts), .req0_rtr(req0_rtr), .req0_x0(req0_x0), .req0_y0(req0_y0),
    .req0_a(req0_a), .req0_b(req0_b), .req0_color(req0_color),
    .req1_rts(req1_rts), .req1_rtr(req1_rtr), .req1_x0(req1_x0), .req1_y0(req1_y0),
    .req1_a(req1_a), .req1_b(req1_b), .req1_color(req1_color),
    .drw_rts(drw_rts), .drw_rtr(drw_rtr), .drw_x0(drw_x0), .drw_y0(drw_y0),
    .drw_a(drw_a), .drw_b(drw_b), .drw_color(drw_color),
    .pt_rts(pt_rts), .pt_rtr(pt_rtr),
    .pt_x_0(pt_x_0), .pt_x_1(pt_x_1), .pt_x_2(pt_x_2), .pt_x_3(pt_x_3),
    .pt_y_0(pt_y_0), .pt_y_1(pt_y_1), .pt_y_2(pt_y_2), .pt_y_3(pt_y_3),
    .pt_color(pt_color),
    .pix_rts(pix_rts), .pix_rtr(pix_rtr), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Pixel sink: records every completed pixel handshake.
  always @(negedge clk) begin
    if (rst_ && pix_rts && pix_rtr) pix_q.push_back({pix_color, pix_y, pix_x});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pack4(input logic [9:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic apply_reset();
    rst_ = 1'b0;
    drw_rtr = 1'b1;
    pt_rts = 1'b0;
    pix_rtr = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
  endtask

  // Drawer stub: offers one burst from RUN, returns at the negedge where pt_rtr is back.
  task automatic run_burst(input logic [39:0] xs, input logic [39:0] ys,
                           input logic [11:0] col, output int gap);
    bit seen;
    gap = 0;
    seen = 1'b0;
    step();
    pt_x_0 = xs[9:0];   pt_x_1 = xs[19:10]; pt_x_2 = xs[29:20]; pt_x_3 = xs[39:30];
    pt_y_0 = ys[9:0];   pt_y_1 = ys[19:10]; pt_y_2 = ys[29:20]; pt_y_3 = ys[39:30];
    pt_color = col;
    pt_rts = 1'b1;
    pix_q.delete();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pt_rtr) seen = 1'b1;
      else step();
    end
    check("pt_accept", 32'(seen), 32'd1);
    step();
    pt_rts = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pt_rtr) seen = 1'b1;
      else begin
        gap++;
        step();
      end
    end
    check("pt_rtr_return", 32'(seen), 32'd1);
  endtask

  // Counts negedges with busy low until busy rises (bounded by lim).
  task automatic idle_wait(input int lim, output int idle);
    bit seen;
    idle = 0;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else begin
        idle++;
        step();
      end
    end
  endtask

  int gap, idle, n;

  initial begin
    req0_rts = 0; req1_rts = 0;
    req0_x0 = 100; req0_y0 = 120; req0_a = 2; req0_b = 1; req0_color = 12'hF00;
    req1_x0 = 200; req1_y0 = 220; req1_a = 2; req1_b = 1; req1_color = 12'h0F0;
    pt_x_0 = 0; pt_x_1 = 0; pt_x_2 = 0; pt_x_3 = 0;
    pt_y_0 = 0; pt_y_1 = 0; pt_y_2 = 0; pt_y_3 = 0; pt_color = 0;
    apply_reset();

    // Reset values
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_drw_rts", drw_rts, 0);
    check("rst_pix_rts", pix_rts, 0);
    check("rst_pt_rtr", pt_rtr, 0);
    check("rst_req_rtr", {req1_rtr, req0_rtr}, 0);
    check("rst_grant", grant_id, 0);
    check("rst_drw_x0", drw_x0, 0);
    check("rst_pix", {pix_color, pix_y, pix_x}, 0);

    // Single command from req0
    step();
    req0_rts = 1;
    @(negedge clk);
    check("req0_rtr", req0_rtr, 1);
    check("req1_rtr_idle", req1_rtr, 0);
    step();
    req0_rts = 0;
    @(negedge clk);
    check("issue_drw_rts", drw_rts, 1);
    check("issue_drw_x0", drw_x0, 100);
    check("issue_drw_y0", drw_y0, 120);
    check("issue_drw_color", drw_color, 12'hF00);
    check("issue_busy", busy, 1);
    step();
    drw_rtr = 0;
    @(negedge clk);
    check("wait_drw_rts", drw_rts, 0);

    // Duplicate removal
    run_burst(pack4(330, 330, 310, 310), pack4(240, 240, 240, 240), 12'hF00, gap);
    check("dup_serial_cycles", gap, 4);
    check("dup_count", pix_q.size(), 2);
    if (pix_q.size() >= 2) begin
      check("dup_pix0", pix_q[0], {12'hF00, 10'd240, 10'd330});
      check("dup_pix1", pix_q[1], {12'hF00, 10'd240, 10'd310});
    end

    // Clipping including wrapped negatives
    run_burst(pack4(5, 5, 1019, 1019), pack4(2, 1022, 2, 1022), 12'h0AB, gap);
    check("clip_serial_cycles", gap, 4);
    check("clip_count", pix_q.size(), 1);
    if (pix_q.size() >= 1) check("clip_pix0", pix_q[0], {12'h0AB, 10'd2, 10'd5});

    // Backpressure: stall 3 cycles on the second pixel
    step();
    pt_x_0 = 1; pt_x_1 = 2; pt_x_2 = 3; pt_x_3 = 4;
    pt_y_0 = 1; pt_y_1 = 2; pt_y_2 = 3; pt_y_3 = 4;
    pt_color = 12'h123;
    pt_rts = 1;
    pix_q.delete();
    @(negedge clk);
    check("bp_pt_rtr_run", pt_rtr, 1);
    step();
    pt_rts = 0;
    @(negedge clk);
    check("bp_first_pix", {pix_rts, pix_x}, {1'b1, 10'd1});
    step();
    pix_rtr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_pix", {pix_rts, pix_color, pix_y, pix_x}, {1'b1, 12'h123, 10'd2, 10'd2});
      check("bp_hold_pt_rtr", pt_rtr, 0);
      step();
    end
    pix_rtr = 1;
    n = 0;
    idle = 0;
    for (int i = 0; i < 20 && idle == 0; i++) begin
      @(negedge clk);
      if (pt_rtr) idle = 1;
      else begin
        n++;
        step();
      end
    end
    check("bp_serial_cycles", 1 + 3 + n, 7);
    check("bp_count", pix_q.size(), 4);
    if (pix_q.size() >= 4) check("bp_pix3", pix_q[3], {12'h123, 10'd4, 10'd4});

    // Drawer finishes -> IDLE
    step();
    drw_rtr = 1;
    step();
    @(negedge clk);
    check("finish_busy", busy, 0);

    // Arbitration with both requesters held from reset
    rst_ = 0;
    req0_rts = 1;
    req1_rts = 1;
    apply_reset();
    idle_wait(10, idle);
    check("arb_idle_first", idle, 1);
    for (int k = 0; k < 4; k++) begin
      check("arb_grant", grant_id, 32'(k % 2));
      check("arb_drw_x0", drw_x0, (k % 2) ? 32'd200 : 32'd100);
      check("arb_rtr_busy", {req1_rtr, req0_rtr}, 0);
      step();
      drw_rtr = 0;
      run_burst(pack4(50, 51, 50, 51), pack4(60, 60, 60, 60), 12'h555, gap);
      check("arb_busy_run", busy, 1);
      check("arb_count", pix_q.size(), 2);
      step();
      drw_rtr = 1;
      if (k == 3) begin
        req0_rts = 0;
        req1_rts = 0;
      end
      step();
      idle_wait(6, idle);
      check("arb_idle_gap", idle, (k == 3) ? 32'd6 : 32'd1);
    end

    // Reset while a pixel is being offered
    step();
    req0_rts = 1;
    req0_x0 = 300;
    step();
    req0_rts = 0;
    step();
    drw_rtr = 0;
    step();
    pt_x_0 = 7; pt_x_1 = 7; pt_x_2 = 7; pt_x_3 = 7;
    pt_y_0 = 8; pt_y_1 = 8; pt_y_2 = 8; pt_y_3 = 8;
    pt_color = 12'hABC;
    pt_rts = 1;
    pix_rtr = 0;
    pix_q.delete();
    @(negedge clk);
    check("rs_pt_rtr", pt_rtr, 1);
    step();
    pt_rts = 0;
    @(negedge clk);
    check("rs_pre_pix_rts", pix_rts, 1);
    #1;
    rst_ = 0;
    drw_rtr = 1;
    pix_rtr = 1;
    @(negedge clk);
    check("rs_pix_rts", pix_rts, 0);
    check("rs_busy", busy, 0);
    check("rs_drw", {drw_rts, drw_color, drw_x0}, 0);
    check("rs_pix", {pix_color, pix_y, pix_x}, 0);
    check("rs_pt_rtr_grant", {pt_rtr, grant_id}, 0);
    check("rs_no_pixel", pix_q.size(), 0);
    step();
    rst_ = 1;
    req0_rts = 1;
    req0_x0 = 321;
    @(negedge clk);
    check("rs_req0_rtr", req0_rtr, 1);
    step();
    req0_rts = 0;
    @(negedge clk);
    check("rs_issue", {drw_rts, drw_x0}, {1'b1, 10'd321});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
